// File: rtl/q3_pkg.sv
// Shared constants and types for the q3 registered 4-input function block.
package q3_pkg;

   typedef logic [3:0] q3_idx_t;

   // f = c'd' + bd, minterms 0,4,5,7,8,12,13,15
   localparam logic [15:0] Q3_DEFAULT_TT = 16'hB1B1;

endpackage

// File: rtl/q3_lut4.sv
// Combinational 16-entry lookup: index {a,b,c,d} selects one truth-table bit.
module q3_lut4
   import q3_pkg::*;
#(
   parameter logic [15:0] TRUTH_TABLE = Q3_DEFAULT_TT
) (
   input  q3_idx_t idx,
   output logic    f_next
);

   assign f_next = TRUTH_TABLE[idx];

endmodule

// File: rtl/q3.sv
// Registered 4-input Boolean function with sticky coverage of applied input codes.
module q3
   import q3_pkg::*;
#(
   parameter logic [15:0] TRUTH_TABLE = Q3_DEFAULT_TT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   output logic        f,
   output logic [15:0] seen,
   output logic        all_seen
);

   q3_idx_t idx;
   logic    f_next;

   assign idx = {a, b, c, d};

   q3_lut4 #(
      .TRUTH_TABLE (TRUTH_TABLE)
   ) u_lut4 (
      .idx    (idx),
      .f_next (f_next)
   );

   // Coverage bits are sticky; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f    <= 1'b0;
         seen <= 16'h0000;
      end else begin
         f    <= f_next;
         seen <= seen | (16'h0001 << idx);
      end
   end

   assign all_seen = &seen;

endmodule

// File: tb/tb_q3.sv
// Scoreboard bench for q3: stimulus pushes expected results, a monitor pops and compares after each edge.
module tb_q3;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst = 1'b0;
   logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic        f, f_alt, all_seen, all_seen_alt;
   logic [15:0] seen, seen_alt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        f;
      logic [15:0] seen;
      logic        all_seen;
      logic        f_alt;
   } exp_t;

   exp_t exp_q[$];

   // Reference: function values for idx 0..15 and a per-code "applied" flag.
   int  ref_tab [16] = '{1,0,0,0,1,1,0,1,1,0,0,0,1,1,0,1};
   bit  cov [16];

   q3 u_dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .f        (f),
      .seen     (seen),
      .all_seen (all_seen)
   );

   q3 #(
      .TRUTH_TABLE (16'h8000)
   ) u_alt (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .f        (f_alt),
      .seen     (seen_alt),
      .all_seen (all_seen_alt)
   );

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [15:0] model_seen();
      logic [15:0] s;
      s = '0;
      for (int i = 0; i < 16; i++) if (cov[i]) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic model_all();
      for (int i = 0; i < 16; i++) if (!cov[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Drive an index now and record what the outputs must show after the next rising edge.
   task automatic drive(input int idx);
      exp_t e;
      {a, b, c, d} = 4'(idx);
      cov[idx]   = 1'b1;
      e.f        = (ref_tab[idx] != 0);
      e.seen     = model_seen();
      e.all_seen = model_all();
      e.f_alt    = (idx == 15);
      exp_q.push_back(e);
   endtask

   // Caller is between edges; covers exactly one rising edge.
   task automatic apply(input int idx);
      drive(idx);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_rst_f"}, 32'(f), 32'd0);
      chk({tag, "_rst_seen"}, 32'(seen), 32'h0);
      chk({tag, "_rst_all"}, 32'(all_seen), 32'd0);
      for (int i = 0; i < 16; i++) cov[i] = 1'b0;
      #1;
      rst = 1'b0;
   endtask

   // Monitor: after each edge, compare against the oldest pending expectation.
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("mon_f", 32'(f), 32'(e.f));
         chk("mon_seen", 32'(seen), 32'(e.seen));
         chk("mon_all_seen", 32'(all_seen), 32'(e.all_seen));
         chk("mon_f_alt", 32'(f_alt), 32'(e.f_alt));
         chk("mon_seen_alt", 32'(seen_alt), 32'(e.seen));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with the clock stopped must act immediately.
      #3;
      rst = 1'b1;
      #1;
      chk("init_rst_f", 32'(f), 32'd0);
      chk("init_rst_seen", 32'(seen), 32'h0);
      chk("init_rst_all", 32'(all_seen), 32'd0);
      chk("init_rst_f_alt", 32'(f_alt), 32'd0);
      clk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Ascending sweep, each code held for two cycles.
      for (int i = 0; i < 16; i++) begin
         apply(i);
         apply(i);
      end
      chk("sweep_seen", 32'(seen), 32'hFFFF);
      chk("sweep_all", 32'(all_seen), 32'd1);

      // Latency: switch idx 1 -> 0 just after an edge; f must hold 0 until the next edge.
      drive(1);
      @(posedge clk);
      #2;
      drive(0);
      #1 chk("lat_hold_a", 32'(f), 32'd0);
      #1 chk("lat_hold_b", 32'(f), 32'd0);
      @(negedge clk);
      chk("lat_hold_c", 32'(f), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_after", 32'(f), 32'd1);

      // Partial coverage.
      pulse_reset("part");
      apply(0);
      apply(5);
      apply(15);
      chk("part_seen", 32'(seen), 32'h8021);
      chk("part_all", 32'(all_seen), 32'd0);

      // Mid-sweep reset.
      pulse_reset("mid_pre");
      for (int i = 0; i < 8; i++) apply(i);
      chk("mid_seen_00ff", 32'(seen), 32'h00FF);
      pulse_reset("mid");
      apply(8);
      chk("mid_seen_0100", 32'(seen), 32'h0100);
      chk("mid_f8", 32'(f), 32'd1);

      // Alternate table: AND of all inputs.
      apply(15);
      chk("alt_f15", 32'(f_alt), 32'd1);
      apply(14);
      chk("alt_f14", 32'(f_alt), 32'd0);

      // Randomized codes with occasional resets.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 49) == 0) pulse_reset("rand");
         apply(int'($urandom_range(0, 15)));
      end

      @(posedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
